// File: rtl/cache_miss_controller.sv
// Miss sequencer for a direct-mapped 4-word-line cache: lookup, RAM line fetch, fill, respond.
// Optional hit/miss performance counters are built when PERF_CNT_EN is defined.
module cache_miss_controller #(
    parameter int ADDR_W  = 15,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 255
) (
    input  logic              globalclock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_done,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_err,
    output logic              cache_wrEn,
    output logic [ADDR_W-1:0] cache_address,
    output logic [LINE_W-1:0] cache_inData,
    input  logic              cache_hit,
    input  logic [31:0]       cache_rdata,
    output logic              mem_req,
    output logic [ADDR_W-3:0] mem_addr,
    input  logic              mem_ack,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);

    localparam int WORDS = LINE_W / 32;
    localparam int TO_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        MEM_WAIT = 3'd2,
        FILL     = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [LINE_W-1:0] line_reg;
    logic [31:0]       cpu_rdata_reg;
    logic              cpu_err_reg;
    logic              mem_req_reg;
    logic [TO_W-1:0]   to_cnt_reg;
    logic              timeout_expired;
    logic [31:0]       line_words [WORDS];
    logic [31:0]       fill_word;

    // Word 0 sits in the most significant 32 bits of the line.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
            assign line_words[gi] = line_reg[LINE_W-1-32*gi -: 32];
        end
    endgenerate

    assign fill_word       = line_words[addr_reg[1:0]];
    assign timeout_expired = (TIMEOUT != 0) && (to_cnt_reg == TO_LAST);

    always_ff @(posedge globalclock) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (cpu_req) state_next = LOOKUP;
            LOOKUP:   state_next = cache_hit ? RESP : MEM_WAIT;
            MEM_WAIT: begin
                if (mem_ack) begin
                    state_next = FILL;
                end else if (timeout_expired) begin
                    state_next = RESP;
                end
            end
            FILL:     state_next = RESP;
            RESP:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        cpu_done   = 1'b0;
        cache_wrEn = 1'b0;
        case (state_reg)
            FILL:    cache_wrEn = 1'b1;
            RESP:    cpu_done   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge globalclock) begin
        if (!reset) begin
            addr_reg      <= '0;
            line_reg      <= '0;
            cpu_rdata_reg <= '0;
            cpu_err_reg   <= 1'b0;
            mem_req_reg   <= 1'b0;
            to_cnt_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cpu_req) addr_reg <= cpu_addr;
                end
                LOOKUP: begin
                    if (cache_hit) begin
                        cpu_rdata_reg <= cache_rdata;
                        cpu_err_reg   <= 1'b0;
                    end else begin
                        mem_req_reg <= 1'b1;
                        to_cnt_reg  <= '0;
                    end
                end
                MEM_WAIT: begin
                    to_cnt_reg <= to_cnt_reg + TO_W'(1);
                    // An ack arriving on the expiry cycle still completes the fetch.
                    if (mem_ack) begin
                        line_reg    <= mem_rdata;
                        mem_req_reg <= 1'b0;
                    end else if (timeout_expired) begin
                        mem_req_reg   <= 1'b0;
                        cpu_err_reg   <= 1'b1;
                        cpu_rdata_reg <= '0;
                    end
                end
                FILL: begin
                    cpu_rdata_reg <= fill_word;
                    cpu_err_reg   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef PERF_CNT_EN
    logic [15:0] hit_count_reg;
    logic [15:0] miss_count_reg;

    always_ff @(posedge globalclock) begin
        if (!reset) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else if (state_reg == LOOKUP) begin
            if (cache_hit) begin
                if (hit_count_reg != 16'hFFFF) hit_count_reg <= hit_count_reg + 16'd1;
            end else begin
                if (miss_count_reg != 16'hFFFF) miss_count_reg <= miss_count_reg + 16'd1;
            end
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
`else
    assign hit_count  = 16'd0;
    assign miss_count = 16'd0;
`endif

    assign cpu_rdata     = cpu_rdata_reg;
    assign cpu_err       = cpu_err_reg;
    assign mem_req       = mem_req_reg;
    assign cache_address = addr_reg;
    assign mem_addr      = addr_reg[ADDR_W-1:2];
    assign cache_inData  = line_reg;

endmodule

// File: tb/tb_cache_miss_controller.sv
// Randomized bench for cache_miss_controller: cache/RAM environment models plus a
// line-level reference that predicts hit/miss, latency, returned word and error.
module tb_cache_miss_controller;

    localparam int TO = 4;

    logic          globalclock = 1'b0;
    logic          reset       = 1'b0;
    logic          cpu_req     = 1'b0;
    logic [14:0]   cpu_addr    = '0;
    logic          cpu_done;
    logic [31:0]   cpu_rdata;
    logic          cpu_err;
    logic          cache_wrEn;
    logic [14:0]   cache_address;
    logic [127:0]  cache_inData;
    logic          cache_hit;
    logic [31:0]   cache_rdata;
    logic          mem_req;
    logic [12:0]   mem_addr;
    logic          mem_ack     = 1'b0;
    logic [127:0]  mem_rdata   = '0;
    logic [15:0]   hit_count;
    logic [15:0]   miss_count;

    int n_vec  = 0;
    int n_miss = 0;
    int ref_hits   = 0;
    int ref_misses = 0;

    bit       ref_valid [1024];
    bit [2:0] ref_tag   [1024];

    bit           c_valid [1024];
    bit [2:0]     c_tag   [1024];
    logic [127:0] c_data  [1024];

    cache_miss_controller #(.ADDR_W(15), .LINE_W(128), .TIMEOUT(TO)) dut (
        .globalclock   (globalclock),
        .reset         (reset),
        .cpu_req       (cpu_req),
        .cpu_addr      (cpu_addr),
        .cpu_done      (cpu_done),
        .cpu_rdata     (cpu_rdata),
        .cpu_err       (cpu_err),
        .cache_wrEn    (cache_wrEn),
        .cache_address (cache_address),
        .cache_inData  (cache_inData),
        .cache_hit     (cache_hit),
        .cache_rdata   (cache_rdata),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    always #5 globalclock = ~globalclock;

    // Cache array environment: combinational lookup, line write on the fill strobe.
    logic [9:0]   cidx;
    logic [127:0] cline;
    assign cidx = cache_address[11:2];
    always_comb begin
        cline       = c_data[cidx];
        cache_hit   = c_valid[cidx] && (c_tag[cidx] == cache_address[14:12]);
        cache_rdata = 32'd0;
        case (cache_address[1:0])
            2'd0: cache_rdata = cline[127:96];
            2'd1: cache_rdata = cline[95:64];
            2'd2: cache_rdata = cline[63:32];
            2'd3: cache_rdata = cline[31:0];
            default: cache_rdata = 32'd0;
        endcase
    end
    always @(posedge globalclock) begin
        if (cache_wrEn) begin
            c_valid[cidx] <= 1'b1;
            c_tag[cidx]   <= cache_address[14:12];
            c_data[cidx]  <= cache_inData;
        end
    end

    function automatic logic [127:0] ram_line(input logic [12:0] la);
        if (la == 13'h0401) return 128'hAAAA0000_BBBB1111_CCCC2222_DDDD3333;
        return {{3'b0, la, 16'h0A00}, {3'b0, la, 16'h1B11}, {3'b0, la, 16'h2C22}, {3'b0, la, 16'h3D33}};
    endfunction

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_perf(input string tag);
`ifdef PERF_CNT_EN
        check_val({tag, "_hits"},   hit_count,  ref_hits);
        check_val({tag, "_misses"}, miss_count, ref_misses);
`else
        check_val({tag, "_hits"},   hit_count,  0);
        check_val({tag, "_misses"}, miss_count, 0);
`endif
    endtask

    // One CPU read; ack_at = index of the mem_req cycle carrying mem_ack (>= TO means never).
    task automatic do_read(input logic [14:0] addr, input int ack_at, input bit drop_req);
        logic [127:0] line;
        logic [31:0]  exp_w;
        logic [31:0]  held;
        bit           exp_hit;
        bit           done;
        int           off, n, reqs, wrs, lat, exp_reqs, exp_wrs;
        logic [31:0]  exp_data;
        bit           exp_err;
        line    = ram_line(addr[14:2]);
        off     = int'(addr[1:0]);
        exp_w   = line[127-32*off -: 32];
        exp_hit = ref_valid[addr[11:2]] && (ref_tag[addr[11:2]] == addr[14:12]);
        if (exp_hit) begin
            lat = 2; exp_reqs = 0; exp_wrs = 0; exp_data = exp_w; exp_err = 0;
            ref_hits++;
        end else if (ack_at < TO) begin
            lat = 4 + ack_at; exp_reqs = ack_at + 1; exp_wrs = 1; exp_data = exp_w; exp_err = 0;
            ref_misses++;
        end else begin
            lat = 2 + TO; exp_reqs = TO; exp_wrs = 0; exp_data = 32'd0; exp_err = 1;
            ref_misses++;
        end
        @(negedge globalclock);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        @(posedge globalclock);
        n = 0; done = 0; reqs = 0; wrs = 0;
        while (!done && n < 60) begin
            @(negedge globalclock);
            n++;
            if (drop_req) cpu_req = 1'b0;
            mem_ack = 1'b0;
            if (n == 1) check_val("cache_address", cache_address, addr);
            if (mem_req) begin
                check_val("mem_addr", mem_addr, addr[14:2]);
                if (reqs == ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = line;
                end
                reqs++;
            end else if ($urandom_range(0, 3) == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            end
            if (cache_wrEn) begin
                wrs++;
                check_val("fill_line", cache_inData, line);
            end
            if (cpu_done) begin
                done    = 1;
                cpu_req = 1'b0;
            end
        end
        check_val("done_seen", done, 1'b1);
        check_val("latency", n, lat);
        check_val("mem_req_cycles", reqs, exp_reqs);
        check_val("wren_pulses", wrs, exp_wrs);
        check_val("cpu_rdata", cpu_rdata, exp_data);
        check_val("cpu_err", cpu_err, exp_err);
        $display("read addr=%h ack_at=%0d hit=%0d rdata=%h err=%0b lat=%0d", addr, ack_at, exp_hit, cpu_rdata, cpu_err, n);
        held = cpu_rdata;
        @(negedge globalclock);
        mem_ack = 1'b0;
        check_val("done_pulse_width", cpu_done, 1'b0);
        check_val("rdata_hold", cpu_rdata, held);
        if (!exp_hit && ack_at < TO) begin
            ref_valid[addr[11:2]] = 1'b1;
            ref_tag[addr[11:2]]   = addr[14:12];
        end
    endtask

    initial begin
        logic [14:0] a;
        repeat (3) @(negedge globalclock);
        check_val("rst_done", cpu_done, 1'b0);
        check_val("rst_rdata", cpu_rdata, 32'd0);
        check_val("rst_err", cpu_err, 1'b0);
        check_val("rst_wren", cache_wrEn, 1'b0);
        check_val("rst_mem_req", mem_req, 1'b0);
        check_val("rst_cache_addr", cache_address, 15'd0);
        check_val("rst_mem_addr", mem_addr, 13'd0);
        check_perf("rst");
        reset = 1'b1;

        do_read(15'h1005, 3, 0);
        do_read(15'h1007, 0, 0);
        do_read(15'h2005, 0, 0);
        do_read(15'h1005, 1, 1);
        do_read(15'h3000, 9, 0);
        do_read(15'h3000, 2, 0);
        do_read(15'h3002, 0, 0);
        check_perf("directed");

        for (int i = 0; i < 150; i++) begin
            a = {3'($urandom_range(0, 3)), 8'h00, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            do_read(a, $urandom_range(0, 5), ($urandom_range(0, 3) == 0));
        end
        check_perf("random");

        // Reset in the middle of a fetch, then a late ack that must be ignored.
        @(negedge globalclock);
        cpu_req  = 1'b1;
        cpu_addr = 15'h5123;
        @(posedge globalclock);
        @(negedge globalclock);
        @(negedge globalclock);
        check_val("midrst_req_before", mem_req, 1'b1);
        reset   = 1'b0;
        cpu_req = 1'b0;
        @(negedge globalclock);
        check_val("midrst_mem_req", mem_req, 1'b0);
        check_val("midrst_done", cpu_done, 1'b0);
        check_val("midrst_rdata", cpu_rdata, 32'd0);
        check_val("midrst_wren", cache_wrEn, 1'b0);
        ref_hits   = 0;
        ref_misses = 0;
        check_perf("midrst");
        reset     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = ram_line(13'h1448);
        for (int k = 0; k < 3; k++) begin
            @(negedge globalclock);
            check_val("late_ack_wren", cache_wrEn, 1'b0);
            check_val("late_ack_done", cpu_done, 1'b0);
        end
        mem_ack = 1'b0;
        do_read(15'h5123, 1, 0);

        // Three fresh-line misses followed by five hits on those lines.
        for (int i = 0; i < 3; i++) begin
            a = {3'd6, 10'(10'h300 + i), 2'(i)};
            do_read(a, i, 0);
        end
        for (int i = 0; i < 5; i++) begin
            a = {3'd6, 10'(10'h300 + (i % 3)), 2'(i)};
            do_read(a, 0, 0);
        end
        check_perf("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
